// File: rtl/ieu_wb_scheduler.sv
// Purpose: arbitrates the single integer regfile write port between the Writeback stage and
//          NREQ long-latency requesters, tracks pending long-latency destinations, raises Decode/WB stalls.
// Latency: port mux and grant are combinational (zero cycles); scoreboard/starvation state updates at the clock edge.
// Backpressure: requesters see one-hot ReqReady; a starved requester steals the slot by asserting StallPipeW.
//
// Ports:
//   clk, reset (sync, active-low)
//   IssueValid/IssueRd             : mark a long-latency destination pending
//   PipeRegWriteW/PipeRdW/PipeResultW : in-order Writeback write request
//   ReqValid/ReqRd/ReqData/ReqReady   : long-latency requesters (packed, index i at [W*i +: W])
//   Rs1D/Rs2D/RdD -> ScoreStallD      : Decode hazard check against pending writes
//   StallPipeW                        : hold Writeback this cycle (starvation slot steal)
//   RegWriteOut/RdOut/ResultOut       : regfile write port
//   BusyVec                           : scoreboard state
// Optional macro IEU_WB_SCORE_BYPASS_EN: Decode ignores a register being written back this cycle.
module ieu_wb_scheduler #(
    parameter int XLEN       = 64,
    parameter int NREQ       = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               IssueValid,
    input  logic [4:0]         IssueRd,
    input  logic               PipeRegWriteW,
    input  logic [4:0]         PipeRdW,
    input  logic [XLEN-1:0]    PipeResultW,
    input  logic [NREQ-1:0]    ReqValid,
    input  logic [5*NREQ-1:0]  ReqRd,
    input  logic [XLEN*NREQ-1:0] ReqData,
    output logic [NREQ-1:0]    ReqReady,
    input  logic [4:0]         Rs1D,
    input  logic [4:0]         Rs2D,
    input  logic [4:0]         RdD,
    output logic               ScoreStallD,
    output logic               StallPipeW,
    output logic               RegWriteOut,
    output logic [4:0]         RdOut,
    output logic [XLEN-1:0]    ResultOut,
    output logic [31:0]        BusyVec
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(STARVE_LIM + 1);

    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;
    logic [31:0]     busy_eff;
    logic [CW-1:0]   starve_cnt;
    logic [PW-1:0]   rr_ptr;

    logic            pipe_own;
    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;
    logic [4:0]      gnt_rd;
    logic [XLEN-1:0] gnt_data;
    int              idx;

    // Slot steal is decoded purely from registered count plus live request presence.
    assign StallPipeW = reset & (starve_cnt >= CW'(STARVE_LIM)) & (|ReqValid);
    assign pipe_own   = reset & PipeRegWriteW & (PipeRdW != 5'd0) & ~StallPipeW;

    // Round-robin search starting just after the last grantee.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_vld && ReqValid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
        if (!reset || pipe_own) begin
            gnt_vld = 1'b0;
        end
    end

    assign gnt_rd   = ReqRd[int'(gnt_idx)*5 +: 5];
    assign gnt_data = ReqData[int'(gnt_idx)*XLEN +: XLEN];
    assign ReqReady = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;

    // A grantee targeting x0 completes its handshake without touching the regfile.
    always_comb begin
        RegWriteOut = 1'b0;
        RdOut       = 5'd0;
        ResultOut   = '0;
        if (pipe_own) begin
            RegWriteOut = 1'b1;
            RdOut       = PipeRdW;
            ResultOut   = PipeResultW;
        end else if (gnt_vld) begin
            RegWriteOut = (gnt_rd != 5'd0);
            RdOut       = gnt_rd;
            ResultOut   = gnt_data;
        end
    end

    assign set_mask = (IssueValid && IssueRd != 5'd0) ? (32'd1 << IssueRd) : 32'd0;
    assign clr_mask = gnt_vld ? (32'd1 << gnt_rd) : 32'd0;
    // Set is applied after clear so a same-cycle reissue keeps the register pending.
    assign busy_nxt = ((busy & ~clr_mask) | set_mask) & ~32'd1;

`ifdef IEU_WB_SCORE_BYPASS_EN
    assign busy_eff = busy & ~(clr_mask & ~set_mask);
`else
    assign busy_eff = busy;
`endif

    assign ScoreStallD = reset & (busy_eff[Rs1D] | busy_eff[Rs2D] | busy_eff[RdD]);
    assign BusyVec     = busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy       <= 32'd0;
            starve_cnt <= '0;
            rr_ptr     <= PW'(NREQ - 1);
        end else begin
            busy <= busy_nxt;
            if (gnt_vld) begin
                rr_ptr <= gnt_idx;
            end
            if ((|ReqValid) && !gnt_vld) begin
                if (starve_cnt < CW'(STARVE_LIM)) begin
                    starve_cnt <= starve_cnt + CW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ieu_wb_scheduler.sv
// Purpose: directed self-checking bench for ieu_wb_scheduler with an expectation queue and a
//          decoupled negedge monitor.
// Latency: expectations are for the cycle in which the stimulus is applied.
// Backpressure: n/a (bench drives requesters directly).
module tb_ieu_wb_scheduler;

`ifdef IEU_WB_SCORE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [6:0] M_RW = 7'h01, M_RD = 7'h02, M_RES = 7'h04, M_RDY = 7'h08;
    localparam logic [6:0] M_SW = 7'h10, M_SD = 7'h20, M_BUSY = 7'h40;

    logic        clk = 1'b0;
    logic        reset;
    logic        IssueValid;
    logic [4:0]  IssueRd;
    logic        PipeRegWriteW;
    logic [4:0]  PipeRdW;
    logic [63:0] PipeResultW;
    logic [1:0]  ReqValid;
    logic [4:0]  rq_rd0, rq_rd1;
    logic [63:0] rq_d0, rq_d1;
    logic [9:0]  ReqRd;
    logic [127:0] ReqData;
    logic [1:0]  ReqReady;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        ScoreStallD, StallPipeW, RegWriteOut;
    logic [4:0]  RdOut;
    logic [63:0] ResultOut;
    logic [31:0] BusyVec;

    assign ReqRd   = {rq_rd1, rq_rd0};
    assign ReqData = {rq_d1, rq_d0};

    always #5 clk = ~clk;

    ieu_wb_scheduler #(.XLEN(64), .NREQ(2), .STARVE_LIM(4)) dut (
        .clk(clk), .reset(reset),
        .IssueValid(IssueValid), .IssueRd(IssueRd),
        .PipeRegWriteW(PipeRegWriteW), .PipeRdW(PipeRdW), .PipeResultW(PipeResultW),
        .ReqValid(ReqValid), .ReqRd(ReqRd), .ReqData(ReqData), .ReqReady(ReqReady),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ScoreStallD(ScoreStallD), .StallPipeW(StallPipeW),
        .RegWriteOut(RegWriteOut), .RdOut(RdOut), .ResultOut(ResultOut), .BusyVec(BusyVec)
    );

    typedef struct {
        logic [95:0] name;
        logic [6:0]  m;
        logic        rw;
        logic [4:0]  rd;
        logic [63:0] res;
        logic [1:0]  rdy;
        logic        sw;
        logic        sd;
        logic [31:0] busy;
    } exp_t;

    exp_t expq[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input logic [95:0] nm, input logic [63:0] fld, input logic [63:0] act,
                         input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %0s.%0s got=%0h expected=%0h", nm, fld, act, want);
        end
    endtask

    task automatic push_exp(input logic [95:0] nm, input logic [6:0] m, input logic rw,
                            input logic [4:0] rd, input logic [63:0] res, input logic [1:0] rdy,
                            input logic sw, input logic sd, input logic [31:0] busy);
        exp_t e;
        e.name = nm; e.m = m; e.rw = rw; e.rd = rd; e.res = res;
        e.rdy = rdy; e.sw = sw; e.sd = sd; e.busy = busy;
        expq.push_back(e);
    endtask

    task automatic idle_inputs();
        IssueValid = 1'b0; IssueRd = 5'd0;
        PipeRegWriteW = 1'b0; PipeRdW = 5'd0; PipeResultW = 64'd0;
        ReqValid = 2'b00; rq_rd0 = 5'd0; rq_rd1 = 5'd0; rq_d0 = 64'd0; rq_d1 = 64'd0;
        Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Monitor: compares every cycle for which an expectation is queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                if (e.m & M_RW)   check(e.name, "regw",   64'(RegWriteOut), 64'(e.rw));
                if (e.m & M_RD)   check(e.name, "rd",     64'(RdOut),       64'(e.rd));
                if (e.m & M_RES)  check(e.name, "result", ResultOut,        e.res);
                if (e.m & M_RDY)  check(e.name, "ready",  64'(ReqReady),    64'(e.rdy));
                if (e.m & M_SW)   check(e.name, "stallw", 64'(StallPipeW),  64'(e.sw));
                if (e.m & M_SD)   check(e.name, "stalld", 64'(ScoreStallD), 64'(e.sd));
                if (e.m & M_BUSY) check(e.name, "busy",   64'(BusyVec),     64'(e.busy));
            end
        end
    end

    localparam logic [6:0] M_ALL = M_RW | M_RD | M_RES | M_RDY | M_SW | M_SD | M_BUSY;
    localparam logic [6:0] M_CTL = M_RW | M_RDY | M_SW | M_SD | M_BUSY;

    initial begin
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);

        // Reset held low with live requests and a pipeline write.
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            reset = 1'b0; ReqValid = 2'b11; PipeRegWriteW = 1'b1; PipeRdW = 5'd3;
            IssueValid = 1'b1; IssueRd = 5'd4; Rs1D = 5'd4;
            push_exp("reset", M_CTL, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        end

        // Pipeline owns the slot even with a pending requester.
        next_cycle();
        reset = 1'b1; PipeRegWriteW = 1'b1; PipeRdW = 5'd5; PipeResultW = 64'h1234;
        ReqValid = 2'b01; rq_rd0 = 5'd6; rq_d0 = 64'hAAAA;
        push_exp("pipe_wr", M_ALL, 1'b1, 5'd5, 64'h1234, 2'b00, 1'b0, 1'b0, 32'd0);
        next_cycle();
        push_exp("idle", M_CTL, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 1'b0, 32'd0);

        // Scoreboard set, Decode stall, clear by requester 0.
        next_cycle();
        IssueValid = 1'b1; IssueRd = 5'd7; Rs1D = 5'd7;
        push_exp("sb_issue", M_SD | M_BUSY, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        next_cycle();
        Rs1D = 5'd7;
        push_exp("sb_stall", M_SD | M_BUSY | M_RW, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 1'b1, 32'h80);
        next_cycle();
        Rs1D = 5'd7; ReqValid = 2'b01; rq_rd0 = 5'd7; rq_d0 = 64'h77;
        push_exp("sb_wb", M_ALL, 1'b1, 5'd7, 64'h77, 2'b01, 1'b0, !BYP, 32'h80);
        next_cycle();
        Rs1D = 5'd7;
        push_exp("sb_clear", M_SD | M_BUSY, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 1'b0, 32'd0);

        // Round-robin: last grantee was 0, so requester 1 goes first.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            ReqValid = 2'b11; rq_rd0 = 5'd10; rq_rd1 = 5'd11; rq_d0 = 64'hA0; rq_d1 = 64'hB1;
            if (i % 2 == 0)
                push_exp("rr", M_ALL, 1'b1, 5'd11, 64'hB1, 2'b10, 1'b0, 1'b0, 32'd0);
            else
                push_exp("rr", M_ALL, 1'b1, 5'd10, 64'hA0, 2'b01, 1'b0, 1'b0, 32'd0);
        end
        // Grantee with rd x0 handshakes without a regfile write.
        next_cycle();
        ReqValid = 2'b10; rq_rd1 = 5'd0; rq_d1 = 64'hEE;
        push_exp("rd_x0", M_RW | M_RDY, 1'b0, 5'd0, 64'd0, 2'b10, 1'b0, 1'b0, 32'd0);

        // Starvation: four ungranted cycles, then the slot is stolen.
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            PipeRegWriteW = 1'b1; PipeRdW = 5'd12; PipeResultW = 64'hC0;
            ReqValid = 2'b01; rq_rd0 = 5'd13; rq_d0 = 64'hD0;
            if (i < 4)
                push_exp("starve", M_ALL, 1'b1, 5'd12, 64'hC0, 2'b00, 1'b0, 1'b0, 32'd0);
            else
                push_exp("steal", M_ALL, 1'b1, 5'd13, 64'hD0, 2'b01, 1'b1, 1'b0, 32'd0);
        end
        next_cycle();
        PipeRegWriteW = 1'b1; PipeRdW = 5'd12; PipeResultW = 64'hC0;
        push_exp("held_wr", M_ALL, 1'b1, 5'd12, 64'hC0, 2'b00, 1'b0, 1'b0, 32'd0);

        // x0 never becomes busy; mid-run reset drops pending state.
        next_cycle();
        IssueValid = 1'b1; IssueRd = 5'd0;
        push_exp("x0_issue", M_BUSY | M_RW, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        next_cycle();
        IssueValid = 1'b1; IssueRd = 5'd9;
        push_exp("x0_busy", M_BUSY, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        next_cycle();
        Rs1D = 5'd9;
        push_exp("r9_stall", M_SD | M_BUSY, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 1'b1, 32'h200);
        next_cycle();
        reset = 1'b0; Rs1D = 5'd9;
        push_exp("mid_rst", M_SD | M_BUSY, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 1'b0, 32'h200);
        next_cycle();
        reset = 1'b1; Rs1D = 5'd9;
        push_exp("post_rst", M_SD | M_BUSY, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 1'b0, 32'd0);

        // Same-cycle set and clear of one register: set wins, no bypass.
        next_cycle();
        IssueValid = 1'b1; IssueRd = 5'd14; Rs2D = 5'd14;
        push_exp("sc_issue", M_SD | M_BUSY, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        next_cycle();
        IssueValid = 1'b1; IssueRd = 5'd14; Rs2D = 5'd14;
        ReqValid = 2'b01; rq_rd0 = 5'd14; rq_d0 = 64'h14;
        push_exp("sc_same", M_ALL, 1'b1, 5'd14, 64'h14, 2'b01, 1'b0, 1'b1, 32'h4000);
        next_cycle();
        RdD = 5'd14;
        push_exp("sc_keep", M_SD | M_BUSY, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 1'b1, 32'h4000);

        // Bounded drain of the expectation queue.
        for (int i = 0; i < 4 && expq.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
